// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: loads instruction and data memory from a 64-bit stream,
// runs the CPU for a fixed number of cycles, then streams data memory out.
module boot_seq_ctrl #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] imem_len,
  input  logic [15:0] dmem_len,
  input  logic [15:0] dump_len,
  input  logic [31:0] run_cycles,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycle_count
);

  localparam logic [15:0] IMEM_MAX = 16'(IMEM_WORDS);
  localparam logic [15:0] DMEM_MAX = 16'(DMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_OUT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q;
  logic [15:0] imem_len_q, dmem_len_q, dump_len_q;
  logic [31:0] run_len_q, run_cnt_q;
  logic        accept;

  // Lengths as they would be latched on accept, clamped to memory depth.
  logic [15:0] imem_clamp, dmem_clamp, dump_clamp;
  assign imem_clamp = (imem_len > IMEM_MAX) ? IMEM_MAX : imem_len;
  assign dmem_clamp = (dmem_len > DMEM_MAX) ? DMEM_MAX : dmem_len;
  assign dump_clamp = (dump_len > DMEM_MAX) ? DMEM_MAX : dump_len;

  // First phase with work to do, in fixed phase order; DONE if none.
  function automatic state_t first_phase(input logic i, input logic d,
                                         input logic r, input logic u);
    state_t s;
    if (i)      s = LOAD_I;
    else if (d) s = LOAD_D;
    else if (r) s = RUN;
    else if (u) s = DUMP_RD;
    else        s = DONE;
    return s;
  endfunction

  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);

  // Next-state logic and combinational port strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    accept      = 1'b0;
    s_ready     = 1'b0;
    cpu_enable  = 1'b0;
    addr_ext    = '0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    wdata_ext   = '0;
    addr_ext_2  = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = first_phase(imem_clamp != '0, dmem_clamp != '0,
                                run_cycles != '0, dump_clamp != '0);
        end
      end
      LOAD_I: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wen_ext   = 1'b1;
          addr_ext  = {46'd0, idx_q, 2'b00};
          wdata_ext = s_data[31:0];
          if (idx_q == imem_len_q - 16'd1)
            state_d = first_phase(1'b0, dmem_len_q != '0,
                                  run_len_q != '0, dump_len_q != '0);
        end
      end
      LOAD_D: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wen_ext_2   = 1'b1;
          addr_ext_2  = {45'd0, idx_q, 3'b000};
          wdata_ext_2 = s_data;
          if (idx_q == dmem_len_q - 16'd1)
            state_d = first_phase(1'b0, 1'b0, run_len_q != '0, dump_len_q != '0);
        end
      end
      RUN: begin
        cpu_enable = 1'b1;
        if (run_cnt_q == run_len_q - 32'd1)
          state_d = first_phase(1'b0, 1'b0, 1'b0, dump_len_q != '0);
      end
      DUMP_RD: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = {45'd0, idx_q, 3'b000};
        state_d    = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (m_valid && m_ready)
          state_d = (idx_q == dump_len_q - 16'd1) ? DONE : DUMP_RD;
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts within the current cycle: no strobe may fire while rst is high.
    if (rst) begin
      state_d    = IDLE;
      accept     = 1'b0;
      s_ready    = 1'b0;
      cpu_enable = 1'b0;
      addr_ext   = '0;
      wen_ext    = 1'b0;
      wdata_ext  = '0;
      addr_ext_2 = '0;
      wen_ext_2  = 1'b0;
      ren_ext_2  = 1'b0;
      wdata_ext_2 = '0;
    end
  end

  // State, index, length latches, run counter and dump output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      imem_len_q  <= '0;
      dmem_len_q  <= '0;
      dump_len_q  <= '0;
      run_len_q   <= '0;
      run_cnt_q   <= '0;
      cycle_count <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        imem_len_q  <= imem_clamp;
        dmem_len_q  <= dmem_clamp;
        dump_len_q  <= dump_clamp;
        run_len_q   <= run_cycles;
        idx_q       <= '0;
        run_cnt_q   <= '0;
        cycle_count <= '0;
        m_valid     <= 1'b0;
      end else begin
        case (state_q)
          LOAD_I, LOAD_D: begin
            if (s_valid)
              idx_q <= (state_d != state_q) ? 16'd0 : idx_q + 16'd1;
          end
          RUN: begin
            run_cnt_q <= run_cnt_q + 32'd1;
            if (cycle_count != 32'hFFFF_FFFF)
              cycle_count <= cycle_count + 32'd1;
          end
          DUMP_OUT: begin
            // First cycle captures the read data; it then holds until accepted.
            if (!m_valid) begin
              m_data  <= rdata_ext_2;
              m_valid <= 1'b1;
            end else if (m_ready) begin
              m_valid <= 1'b0;
              idx_q   <= (state_d == DONE) ? 16'd0 : idx_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed testbench for boot_seq_ctrl with simple instruction/data memory models.
module tb_boot_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] imem_len, dmem_len, dump_len;
  logic [31:0] run_cycles;
  logic        s_valid, s_ready;
  logic [63:0] s_data;
  logic        m_valid, m_ready;
  logic [63:0] m_data;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2, ren_ext_2;
  logic [63:0] wdata_ext_2, rdata_ext_2;
  logic        busy, done;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  // Observation logs filled by the monitor.
  logic [63:0] wi_addr[$];
  logic [63:0] wi_data[$];
  logic [63:0] wd_addr[$];
  logic [63:0] wd_data[$];
  logic [63:0] dumped[$];
  int          ren_count, en_count, conflict_count;

  logic [63:0] dmem[128];

  boot_seq_ctrl #(.IMEM_WORDS(128), .DMEM_WORDS(128)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .dump_len(dump_len),
    .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Data memory model with one-cycle registered read.
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[9:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:3]];
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (wen_ext) begin wi_addr.push_back(addr_ext); wi_data.push_back(64'(wdata_ext)); end
    if (wen_ext_2) begin wd_addr.push_back(addr_ext_2); wd_data.push_back(wdata_ext_2); end
    if (ren_ext_2) ren_count++;
    if (cpu_enable) en_count++;
    if (m_valid && m_ready) dumped.push_back(m_data);
    if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) conflict_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wi_addr.delete(); wi_data.delete(); wd_addr.delete(); wd_data.delete();
    dumped.delete();
    ren_count = 0; en_count = 0; conflict_count = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic start_seq(input logic [15:0] il, input logic [15:0] dl,
                           input logic [31:0] rc, input logic [15:0] ul);
    imem_len = il; dmem_len = dl; run_cycles = rc; dump_len = ul;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Offer one beat and hold it until consumed; optional idle cycle after.
  task automatic send(input logic [63:0] w, input bit gap);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (s_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (gap) cyc();
  endtask

  task automatic wait_done(input int bound);
    for (int n = 0; n < bound; n++) begin
      if (done) break;
      cyc();
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    logic [63:0] hold;
    int          ren_snap, unstable;
    bit          seen;

    for (int i = 0; i < 128; i++) dmem[i] = '0;
    rdata_ext_2 = '0;
    imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = '0; s_data = '0;
    do_reset();

    // Reset state.
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_wen_ext", 64'(wen_ext), 64'd0);

    // Full sequence: 3 instruction words, 2 data words, 10 run cycles, dump 2.
    start_seq(16'd3, 16'd2, 32'd10, 16'd2);
    check("seq_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) send(64'h13, 1'b0);
    send(64'h11, 1'b0);
    send(64'h22, 1'b0);
    wait_done(200);
    check("seq_wi_cnt", 64'(wi_addr.size()), 64'd3);
    check("seq_wi_a0", wi_addr[0], 64'd0);
    check("seq_wi_a1", wi_addr[1], 64'd4);
    check("seq_wi_a2", wi_addr[2], 64'd8);
    check("seq_wi_d2", wi_data[2], 64'h13);
    check("seq_wd_cnt", 64'(wd_addr.size()), 64'd2);
    check("seq_wd_a0", wd_addr[0], 64'd0);
    check("seq_wd_a1", wd_addr[1], 64'd8);
    check("seq_en_cnt", 64'(en_count), 64'd10);
    check("seq_cycle_count", 64'(cycle_count), 64'd10);
    check("seq_dump_cnt", 64'(dumped.size()), 64'd2);
    check("seq_dump0", dumped[0], 64'h11);
    check("seq_dump1", dumped[1], 64'h22);
    check("seq_ren_cnt", 64'(ren_count), 64'd2);
    check("seq_busy_end", 64'(busy), 64'd0);

    // All lengths zero: DONE one cycle after start with no activity.
    do_reset();
    check("zero_done_pre", 64'(done), 64'd0);
    start_seq(16'd0, 16'd0, 32'd0, 16'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    cyc();
    check("zero_activity", 64'(wi_addr.size() + wd_addr.size() + ren_count + en_count), 64'd0);

    // Load with s_valid toggling every other cycle.
    do_reset();
    start_seq(16'd4, 16'd0, 32'd0, 16'd0);
    for (int i = 0; i < 4; i++) send(64'hA0 + 64'(i), 1'b1);
    wait_done(40);
    check("gap_cnt", 64'(wi_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gap_addr%0d", i), wi_addr[i], 64'(4 * i));
      check($sformatf("gap_data%0d", i), wi_data[i], 64'hA0 + 64'(i));
    end

    // Dump back-pressure: m_ready low 5 cycles.
    do_reset();
    m_ready = 1'b0;
    start_seq(16'd0, 16'd0, 32'd0, 16'd2);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (m_valid) begin seen = 1'b1; break; end
      cyc();
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    hold = m_data;
    ren_snap = ren_count;
    unstable = 0;
    for (int n = 0; n < 5; n++) begin
      cyc();
      if (!m_valid || m_data !== hold) unstable++;
    end
    check("bp_data", hold, 64'h11);
    check("bp_stable", 64'(unstable), 64'd0);
    check("bp_no_reread", 64'(ren_count), 64'(ren_snap));
    check("bp_ren_first", 64'(ren_snap), 64'd1);
    m_ready = 1'b1;
    wait_done(40);
    check("bp_dump1", dumped[1], 64'h22);
    check("bp_ren_total", 64'(ren_count), 64'd2);

    // Reset during cycle 4 of RUN.
    do_reset();
    start_seq(16'd0, 16'd0, 32'd20, 16'd0);
    cyc(); cyc(); cyc();
    check("abort_cc_before", 64'(cycle_count), 64'd3);
    rst = 1'b1;
    cyc();
    check("abort_cpu_enable", 64'(cpu_enable), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cc", 64'(cycle_count), 64'd0);
    rst = 1'b0;

    // start during RUN is ignored.
    do_reset();
    start_seq(16'd0, 16'd0, 32'd10, 16'd1);
    cyc(); cyc(); cyc();
    start_seq(16'd5, 16'd5, 32'd3, 16'd5);
    wait_done(60);
    check("ign_en_cnt", 64'(en_count), 64'd10);
    check("ign_cycle_count", 64'(cycle_count), 64'd10);
    check("ign_no_load", 64'(wi_addr.size() + wd_addr.size()), 64'd0);
    check("ign_dump_cnt", 64'(dumped.size()), 64'd1);
    check("ign_dump0", dumped[0], 64'h11);

    // Oversized instruction length clamps to depth.
    do_reset();
    start_seq(16'd600, 16'd0, 32'd0, 16'd0);
    for (int i = 0; i < 128; i++) send(64'(i), 1'b0);
    cyc();
    check("clamp_done", 64'(done), 64'd1);
    s_valid = 1'b1;
    cyc(); cyc();
    s_valid = 1'b0;
    check("clamp_cnt", 64'(wi_addr.size()), 64'd128);
    check("clamp_last_addr", wi_addr[127], 64'd508);
    check("no_port_conflict", 64'(conflict_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
